// File: rtl/qtree_loader_pkg.sv
// Shared types and helpers for the QTree stream loader: FSM states, error
// codes and the geometry of child-pointer fields inside a node payload.
package qtree_loader_pkg;

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_WAITPTR = 3'd2,
        ST_GO      = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0] ERR_FRAMING   = 2'd3;

    // Stack pointer must be able to hold the value STACK_DEPTH (a full stack).
    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ri_width(input int n_roots);
        return $clog2(n_roots) + 1;
    endfunction

    // Lowest bit of child field k; child 0 sits just above the tag.
    function automatic int child_lo(input int tag_w, input int ptr_w, input int k);
        return tag_w + k * ptr_w;
    endfunction

endpackage

// File: rtl/ptr_stack.sv
// Pointer stack: synchronous push, pop of ARITY entries at once, and a
// combinational view of the top ARITY entries (oldest first) for patching.
module ptr_stack
    import qtree_loader_pkg::*;
#(
    parameter int PTR_W       = 16,
    parameter int ARITY       = 4,
    parameter int STACK_DEPTH = 256,
    parameter int SP_W        = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic [PTR_W-1:0]       push_ptr_i,
    input  logic                   pop_i,
    output logic [SP_W-1:0]        sp_o,
    output logic [ARITY*PTR_W-1:0] top_o
);

    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] DEPTH_SP = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0] ARITY_SP = SP_W'(ARITY);

    logic [PTR_W-1:0] mem_q [STACK_DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic [SP_W-1:0]  sp_d;
    logic [SP_W-1:0]  rd_idx;

    always_comb begin
        sp_d = sp_q;
        if (clear_i) begin
            sp_d = '0;
        end else if (push_i && (sp_q < DEPTH_SP)) begin
            sp_d = sp_q + SP_W'(1);
        end else if (pop_i && (sp_q >= ARITY_SP)) begin
            sp_d = sp_q - ARITY_SP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clear_i && (sp_q < DEPTH_SP)) begin
            mem_q[sp_q[AW-1:0]] <= push_ptr_i;
        end
    end

    // Out-of-range reads (stack shallower than ARITY) return zero; the
    // controller never consumes them because it traps underflow first.
    always_comb begin
        top_o  = '0;
        rd_idx = '0;
        for (int k = 0; k < ARITY; k++) begin
            rd_idx = sp_q - ARITY_SP + SP_W'(k);
            if (rd_idx < DEPTH_SP) begin
                top_o[k*PTR_W +: PTR_W] = mem_q[rd_idx[AW-1:0]];
            end
        end
    end

    assign sp_o = sp_q;

endmodule

// File: rtl/qtree_stream_loader.sv
// Loads postfix-ordered QTree node streams into the heap, patching child
// pointers from a pointer stack, then hands all tree roots over with one Go.
module qtree_stream_loader
    import qtree_loader_pkg::*;
#(
    parameter int NODE_W      = 66,
    parameter int PTR_W       = 16,
    parameter int TAG_W       = 2,
    parameter int ARITY       = 4,
    parameter int STACK_DEPTH = 256,
    parameter int N_ROOTS     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NODE_W-1:0]        i_tdata,
    input  logic                     i_tuser,
    input  logic                     i_tlast,
    input  logic                     i_tvalid,
    output logic                     i_tready,
    output logic [NODE_W-1:0]        wr_d,
    output logic                     wr_valid,
    input  logic                     wr_ready,
    input  logic [PTR_W-1:0]         ptr_d,
    input  logic                     ptr_valid,
    output logic                     ptr_ready,
    output logic [N_ROOTS*PTR_W-1:0] roots_d,
    output logic                     go_valid,
    input  logic                     go_ready,
    input  logic                     clear,
    output logic                     busy,
    output logic                     error,
    output logic [1:0]               err_code
);

    localparam int SP_W = sp_width(STACK_DEPTH);
    localparam int RI_W = ri_width(N_ROOTS);
    localparam logic [SP_W-1:0] DEPTH_SP = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0] ARITY_SP = SP_W'(ARITY);
    localparam logic [RI_W-1:0] LAST_RI  = RI_W'(N_ROOTS - 1);

    if (TAG_W + ARITY * PTR_W > NODE_W) begin : g_bad_geometry
        $error("qtree_stream_loader: child pointer fields do not fit in NODE_W");
    end

    state_e                   state_q, state_d;
    logic [NODE_W-1:0]        wr_data_q, wr_data_d;
    logic [N_ROOTS*PTR_W-1:0] root_vec_q, root_vec_d;
    logic [RI_W-1:0]          root_idx_q, root_idx_d;
    logic                     is_last_q, is_last_d;
    logic                     error_q, error_d;
    logic [1:0]               err_code_q, err_code_d;

    logic                     stk_push;
    logic                     stk_pop;
    logic                     stk_clear;
    logic [SP_W-1:0]          sp;
    logic [ARITY*PTR_W-1:0]   stk_top;
    logic [NODE_W-1:0]        patched;

    ptr_stack #(
        .PTR_W       (PTR_W),
        .ARITY       (ARITY),
        .STACK_DEPTH (STACK_DEPTH),
        .SP_W        (SP_W)
    ) u_ptr_stack (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (stk_clear),
        .push_i     (stk_push),
        .push_ptr_i (ptr_d),
        .pop_i      (stk_pop),
        .sp_o       (sp),
        .top_o      (stk_top)
    );

    // Oldest stacked pointer is the first-streamed child, i.e. child 0.
    always_comb begin
        patched = i_tdata;
        for (int k = 0; k < ARITY; k++) begin
            patched[child_lo(TAG_W, PTR_W, k) +: PTR_W] = stk_top[k*PTR_W +: PTR_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_data_d  = wr_data_q;
        root_vec_d = root_vec_q;
        root_idx_d = root_idx_q;
        is_last_d  = is_last_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_clear  = 1'b0;

        if (clear) begin
            state_d    = ST_LOAD;
            root_idx_d = '0;
            error_d    = 1'b0;
            err_code_d = ERR_NONE;
            stk_clear  = 1'b1;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (i_tvalid) begin
                        is_last_d = i_tlast;
                        if (!i_tuser) begin
                            wr_data_d = i_tdata;
                            state_d   = ST_WRITE;
                        end else if (sp >= ARITY_SP) begin
                            wr_data_d = patched;
                            stk_pop   = 1'b1;
                            state_d   = ST_WRITE;
                        end else begin
                            error_d    = 1'b1;
                            err_code_d = ERR_UNDERFLOW;
                            state_d    = ST_ERR;
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_ready) begin
                        state_d = ST_WAITPTR;
                    end
                end
                ST_WAITPTR: begin
                    if (ptr_valid) begin
                        if (!is_last_q) begin
                            if (sp == DEPTH_SP) begin
                                error_d    = 1'b1;
                                err_code_d = ERR_OVERFLOW;
                                state_d    = ST_ERR;
                            end else begin
                                stk_push = 1'b1;
                                state_d  = ST_LOAD;
                            end
                        end else if (sp != '0) begin
                            error_d    = 1'b1;
                            err_code_d = ERR_FRAMING;
                            state_d    = ST_ERR;
                        end else begin
                            for (int k = 0; k < N_ROOTS; k++) begin
                                if (root_idx_q == RI_W'(k)) begin
                                    root_vec_d[k*PTR_W +: PTR_W] = ptr_d;
                                end
                            end
                            root_idx_d = root_idx_q + RI_W'(1);
                            state_d    = (root_idx_q == LAST_RI) ? ST_GO : ST_LOAD;
                        end
                    end
                end
                ST_GO: begin
                    if (go_ready) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            wr_data_q  <= '0;
            root_vec_q <= '0;
            root_idx_q <= '0;
            is_last_q  <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            wr_data_q  <= wr_data_d;
            root_vec_q <= root_vec_d;
            root_idx_q <= root_idx_d;
            is_last_q  <= is_last_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    assign i_tready  = (state_q == ST_LOAD);
    assign wr_valid  = (state_q == ST_WRITE);
    assign ptr_ready = (state_q == ST_WAITPTR);
    assign go_valid  = (state_q == ST_GO);
    assign busy      = (state_q != ST_LOAD);
    assign wr_d      = wr_data_q;
    assign roots_d   = root_vec_q;
    assign error     = error_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_qtree_stream_loader.sv
// Directed bench for qtree_stream_loader: root capture, child patching,
// error traps, clear, backpressure and asynchronous reset.
module tb_qtree_stream_loader;

    localparam int NODE_W = 66;
    localparam int PTR_W  = 16;
    localparam int TAG_W  = 2;
    localparam int ARITY  = 4;
    localparam int DEPTH  = 4;
    localparam int NR     = 2;

    logic                clk;
    logic                reset;
    logic [NODE_W-1:0]   i_tdata;
    logic                i_tuser;
    logic                i_tlast;
    logic                i_tvalid;
    logic                i_tready;
    logic [NODE_W-1:0]   wr_d;
    logic                wr_valid;
    logic                wr_ready;
    logic [PTR_W-1:0]    ptr_d;
    logic                ptr_valid;
    logic                ptr_ready;
    logic [NR*PTR_W-1:0] roots_d;
    logic                go_valid;
    logic                go_ready;
    logic                clear;
    logic                busy;
    logic                error;
    logic [1:0]          err_code;

    int checks   = 0;
    int failures = 0;

    qtree_stream_loader #(
        .NODE_W      (NODE_W),
        .PTR_W       (PTR_W),
        .TAG_W       (TAG_W),
        .ARITY       (ARITY),
        .STACK_DEPTH (DEPTH),
        .N_ROOTS     (NR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_tdata   (i_tdata),
        .i_tuser   (i_tuser),
        .i_tlast   (i_tlast),
        .i_tvalid  (i_tvalid),
        .i_tready  (i_tready),
        .wr_d      (wr_d),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .ptr_d     (ptr_d),
        .ptr_valid (ptr_valid),
        .ptr_ready (ptr_ready),
        .roots_d   (roots_d),
        .go_valid  (go_valid),
        .go_ready  (go_ready),
        .clear     (clear),
        .busy      (busy),
        .error     (error),
        .err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Stimulus helpers: all driving happens at negedge.
    task automatic send_node(input logic [NODE_W-1:0] d, input logic u, input logic l);
        int n = 0;
        i_tdata  = d;
        i_tuser  = u;
        i_tlast  = l;
        i_tvalid = 1'b1;
        while (i_tready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (i_tready !== 1'b1) begin
            failures++;
            $display("FAIL send_timeout i_tready=%b required 1", i_tready);
        end
        @(negedge clk);
        i_tvalid = 1'b0;
        i_tuser  = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic serve(input logic [PTR_W-1:0] p, output logic [NODE_W-1:0] seen);
        int n = 0;
        while (wr_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (wr_valid !== 1'b1) begin
            failures++;
            $display("FAIL serve_timeout wr_valid=%b required 1", wr_valid);
        end
        seen     = wr_d;
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready  = 1'b0;
        ptr_d     = p;
        ptr_valid = 1'b1;
        @(negedge clk);
        ptr_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        i_tdata   = '0;
        i_tuser   = 1'b0;
        i_tlast   = 1'b0;
        i_tvalid  = 1'b0;
        wr_ready  = 1'b0;
        ptr_d     = '0;
        ptr_valid = 1'b0;
        go_ready  = 1'b0;
        clear     = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({i_tready, wr_valid, ptr_ready, go_valid, busy, error} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_flags got=%b required=100000",
                     {i_tready, wr_valid, ptr_ready, go_valid, busy, error});
        end
        checks++;
        if (err_code !== 2'd0 || roots_d !== '0 || wr_d !== '0) begin
            failures++;
            $display("FAIL reset_data err_code=%0d roots=%h wr_d=%h required 0", err_code, roots_d, wr_d);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (i_tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release i_tready=%b required 1", i_tready);
        end
    endtask

    task automatic test_two_leaves();
        logic [NODE_W-1:0] seen;
        logic [NODE_W-1:0] leaf_a;
        logic [NODE_W-1:0] leaf_b;
        leaf_a = 66'h1_2345_6789_ABCD_EF01;
        leaf_b = 66'h2_0000_0000_0000_00B4;
        do_clear();
        send_node(leaf_a, 1'b0, 1'b1);
        serve(16'h0005, seen);
        checks++;
        if (seen !== leaf_a) begin
            failures++;
            $display("FAIL leaf_write got=%h required=%h", seen, leaf_a);
        end
        checks++;
        if (roots_d[15:0] !== 16'h0005 || go_valid !== 1'b0 || i_tready !== 1'b1) begin
            failures++;
            $display("FAIL first_root root0=%h go=%b tready=%b required 0005/0/1",
                     roots_d[15:0], go_valid, i_tready);
        end
        send_node(leaf_b, 1'b0, 1'b1);
        serve(16'h0009, seen);
        checks++;
        if (roots_d !== 32'h0009_0005 || go_valid !== 1'b1) begin
            failures++;
            $display("FAIL roots_go roots=%h go=%b required 00090005/1", roots_d, go_valid);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (go_valid !== 1'b1) begin
            failures++;
            $display("FAIL go_hold go_valid=%b required 1", go_valid);
        end
        go_ready = 1'b1;
        @(negedge clk);
        go_ready = 1'b0;
        checks++;
        if ({go_valid, i_tready, wr_valid, busy} !== 4'b0001 || roots_d !== 32'h0009_0005) begin
            failures++;
            $display("FAIL done_state go/tready/wr/busy=%b roots=%h required 0001/00090005",
                     {go_valid, i_tready, wr_valid, busy}, roots_d);
        end
    endtask

    task automatic test_internal();
        logic [NODE_W-1:0] seen;
        logic [NODE_W-1:0] expect_node;
        expect_node = {16'h0004, 16'h0003, 16'h0002, 16'h0001, 2'b10};
        do_clear();
        for (int i = 1; i <= 4; i++) begin
            send_node(NODE_W'(i * 16'h0101), 1'b0, 1'b0);
            serve(PTR_W'(i), seen);
        end
        send_node({64'hDEAD_BEEF_CAFE_F00D, 2'b10}, 1'b1, 1'b1);
        serve(16'h0010, seen);
        checks++;
        if (seen !== expect_node) begin
            failures++;
            $display("FAIL patch got=%h required=%h", seen, expect_node);
        end
        checks++;
        if (roots_d[15:0] !== 16'h0010 || i_tready !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL internal_root root0=%h tready=%b error=%b required 0010/1/0",
                     roots_d[15:0], i_tready, error);
        end
        // A lone leaf tree only completes cleanly if the stack was emptied.
        send_node(66'h0_0000_0000_0000_0ABC, 1'b0, 1'b1);
        serve(16'h0020, seen);
        checks++;
        if (roots_d !== 32'h0020_0010 || go_valid !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL internal_go roots=%h go=%b error=%b required 00200010/1/0",
                     roots_d, go_valid, error);
        end
    endtask

    task automatic test_underflow();
        do_clear();
        send_node({64'h0, 2'b01}, 1'b1, 1'b0);
        checks++;
        if ({error, err_code, wr_valid, i_tready} !== 5'b10100) begin
            failures++;
            $display("FAIL underflow error/code/wr/tready=%b required 10100",
                     {error, err_code, wr_valid, i_tready});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_valid !== 1'b0 || error !== 1'b1 || err_code !== 2'd1) begin
            failures++;
            $display("FAIL underflow_sticky wr=%b error=%b code=%0d required 0/1/1",
                     wr_valid, error, err_code);
        end
        do_clear();
        checks++;
        if (error !== 1'b0 || err_code !== 2'd0 || i_tready !== 1'b1) begin
            failures++;
            $display("FAIL clear_err error=%b code=%0d tready=%b required 0/0/1",
                     error, err_code, i_tready);
        end
    endtask

    task automatic test_overflow();
        logic [NODE_W-1:0] seen;
        do_clear();
        for (int i = 1; i <= 4; i++) begin
            send_node(NODE_W'(i), 1'b0, 1'b0);
            serve(PTR_W'(i + 8), seen);
        end
        checks++;
        if (error !== 1'b0 || i_tready !== 1'b1) begin
            failures++;
            $display("FAIL stack_full error=%b tready=%b required 0/1", error, i_tready);
        end
        send_node(NODE_W'(5), 1'b0, 1'b0);
        serve(16'h000D, seen);
        checks++;
        if (error !== 1'b1 || err_code !== 2'd2) begin
            failures++;
            $display("FAIL overflow error=%b code=%0d required 1/2", error, err_code);
        end
    endtask

    task automatic test_framing();
        logic [NODE_W-1:0] seen;
        do_clear();
        send_node(NODE_W'(7), 1'b0, 1'b0);
        serve(16'h0001, seen);
        send_node(NODE_W'(8), 1'b0, 1'b1);
        serve(16'h0002, seen);
        checks++;
        if (error !== 1'b1 || err_code !== 2'd3) begin
            failures++;
            $display("FAIL framing error=%b code=%0d required 1/3", error, err_code);
        end
    endtask

    task automatic test_clear_write();
        logic [NODE_W-1:0] seen;
        do_clear();
        send_node(NODE_W'(66'h1_1111), 1'b0, 1'b0);
        checks++;
        if (wr_valid !== 1'b1) begin
            failures++;
            $display("FAIL clr_write_pre wr_valid=%b required 1", wr_valid);
        end
        clear    = 1'b1;
        wr_ready = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        wr_ready = 1'b0;
        checks++;
        if ({wr_valid, ptr_ready, i_tready} !== 3'b001) begin
            failures++;
            $display("FAIL clr_priority wr/ptr_ready/tready=%b required 001",
                     {wr_valid, ptr_ready, i_tready});
        end
        ptr_d     = 16'h0077;
        ptr_valid = 1'b1;
        @(negedge clk);
        ptr_valid = 1'b0;
        checks++;
        if (ptr_ready !== 1'b0 || i_tready !== 1'b1) begin
            failures++;
            $display("FAIL stale_ptr ptr_ready=%b tready=%b required 0/1", ptr_ready, i_tready);
        end
        send_node(NODE_W'(3), 1'b0, 1'b1);
        serve(16'h0031, seen);
        send_node(NODE_W'(4), 1'b0, 1'b1);
        serve(16'h0032, seen);
        checks++;
        if (roots_d !== 32'h0032_0031 || go_valid !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL restart roots=%h go=%b error=%b required 00320031/1/0",
                     roots_d, go_valid, error);
        end
    endtask

    task automatic test_backpressure();
        logic [NODE_W-1:0] bp;
        bp = 66'h3_1111_2222_3333_4444;
        do_clear();
        send_node(bp, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({wr_valid, i_tready, wr_d} !== {1'b1, 1'b0, bp}) begin
                failures++;
                $display("FAIL wr_stall cyc=%0d wr=%b tready=%b wr_d=%h required 1/0/%h",
                         c, wr_valid, i_tready, wr_d, bp);
            end
            @(negedge clk);
        end
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({ptr_ready, i_tready, wr_valid} !== 3'b100) begin
                failures++;
                $display("FAIL ptr_wait cyc=%0d ptr_ready/tready/wr=%b required 100",
                         c, {ptr_ready, i_tready, wr_valid});
            end
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({i_tready, wr_valid, ptr_ready, go_valid, error, busy} !== 6'b100000 ||
            err_code !== 2'd0 || wr_d !== '0 || roots_d !== '0) begin
            failures++;
            $display("FAIL async_reset flags=%b code=%0d wr_d=%h roots=%h required 100000/0/0/0",
                     {i_tready, wr_valid, ptr_ready, go_valid, error, busy}, err_code, wr_d, roots_d);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_two_leaves();
        test_internal();
        test_underflow();
        test_overflow();
        test_framing();
        test_clear_write();
        test_backpressure();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qtree_stream_loader.md
Name: qtree_stream_loader

Overview:
- Parametrised successor to the per-type stream loaders in the QTree benchmark wrappers.
- Accepts one or more trees as an AXI-stream of nodes in postfix order and writes each node to the heap write port.
- Collects the returned heap pointers on a bounded pointer stack and patches child pointers into internal nodes.
- Captures one root pointer per tree, then presents all roots to the DUT together with a single Go handshake. Adds overflow/underflow/framing error detection and a restart (`clear`) that the single-shot loaders lack.

Parameters:
- NODE_W, 66: node payload width in bits; stream data and heap write data.
- PTR_W, 16: heap pointer width.
- TAG_W, 2: constructor tag width at payload bits [TAG_W-1:0].
- ARITY, 4: child count of an internal node.
- STACK_DEPTH, 256: pointer stack entries.
- N_ROOTS, 2: trees per load (number of tlast beats).
- Elaboration check: TAG_W+ARITY*PTR_W <= NODE_W.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- i_tdata  in  NODE_W  node payload.
- i_tuser  in  1  1 = internal node (children patched), 0 = leaf.
- i_tlast  in  1  last node of the current tree.
- i_tvalid  in  1  stream valid.
- i_tready  out  1  stream ready.
- wr_d  out  NODE_W  heap write data.
- wr_valid  out  1  heap write valid.
- wr_ready  in  1  heap write ready.
- ptr_d  in  PTR_W  pointer returned by the heap for the last write.
- ptr_valid  in  1  pointer valid.
- ptr_ready  out  1  pointer ready.
- roots_d  out  N_ROOTS*PTR_W  root k at bits [(k+1)*PTR_W-1 : k*PTR_W].
- go_valid  out  1  roots valid / Go.
- go_ready  in  1  DUT accepts Go.
- clear  in  1  synchronous restart to LOAD.
- busy  out  1  state is not LOAD or is WRITE/WAITPTR.
- error  out  1  sticky error.
- err_code  out  2  0 none, 1 underflow, 2 overflow, 3 framing.

Behaviour:
- Reset (async): state=LOAD; sp=0; root_idx=0; all valids, error and err_code = 0; roots_d=0; wr_d=0. i_tready is 1 in LOAD, so it reads 1 after reset.
- States: LOAD, WRITE, WAITPTR, GO, DONE, ERR.
- LOAD:
  - i_tready=1. On i_tvalid&&i_tready, latch is_last=i_tlast.
  - Leaf: wr_d<=i_tdata.
  - Internal with sp>=ARITY: wr_d<=i_tdata with child field k, bits [TAG_W+(k+1)*PTR_W-1 : TAG_W+k*PTR_W], set to stack[sp-ARITY+k]. The first-streamed child is child 0. sp<=sp-ARITY.
  - Internal with sp<ARITY: err_code=1, go to ERR.
  - Otherwise go to WRITE.
- WRITE: wr_valid=1, wr_d held stable. On wr_ready go to WAITPTR.
- WAITPTR: ptr_ready=1. On ptr_valid:
  - is_last=0, sp==STACK_DEPTH: err_code=2, go to ERR.
  - is_last=0 otherwise: stack[sp]<=ptr_d, sp++, go to LOAD.
  - is_last=1, sp!=0 (leftover operands): err_code=3, go to ERR.
  - is_last=1, sp==0: roots[root_idx]<=ptr_d, root_idx++. If root_idx==N_ROOTS-1 go to GO, else LOAD.
- GO: go_valid=1, roots_d stable. On go_ready go to DONE.
- DONE: all handshakes idle, i_tready=0; roots_d retained.
- ERR: error=1, i_tready=0, no writes. error and err_code hold until clear or reset.
- clear (any state): state=LOAD, sp=0, root_idx=0, error=0, err_code=0, all valids 0 next cycle.
- Clear during WRITE: abandon the write. A pointer returned later is ignored (ptr_ready=0 outside WAITPTR).
- clear has priority over any simultaneous handshake.
- Minimum throughput: one node per 3 cycles with wr_ready and ptr_valid held high.
- Handshakes are AXI-style: valid must not drop before ready; data stable while valid.
- sp is $clog2(STACK_DEPTH+1) bits. root_idx is $clog2(N_ROOTS)+1 bits.

Decomposition:
- qtree_loader_pkg: state enum, err_code constants, child-field offset function, SP_W/RI_W localparams.
- Sub-module ptr_stack: synchronous-write, combinational-read array of depth STACK_DEPTH. Supports push and pop-ARITY with a parallel read of the top ARITY entries.

Test Plan:
- N_ROOTS=2; tree A = one leaf with tlast, tree B = one leaf with tlast; heap returns 0x0005 then 0x0009 -> roots_d={0x0009,0x0005}, go_valid=1 until go_ready, then DONE with i_tready=0.
- Four leaves (ptrs 1,2,3,4) then an internal node with tlast -> that write has child0..3 = 1,2,3,4; its returned pointer 0x0010 becomes root0; sp=0.
- Internal node as first beat -> err_code=1, error=1, no wr_valid; clear -> LOAD, error=0.
- STACK_DEPTH=4; five non-last leaves -> the fifth pointer return gives err_code=2.
- Two leaves, second with tlast -> err_code=3.
- Backpressure: wr_ready low for 5 cycles and ptr_valid delayed 3 cycles -> wr_d stable, i_tready=0 throughout; asynchronous reset mid-WAITPTR -> all outputs at reset values immediately.
